quick_uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one `quick_uart_tx` among `N_REQ` byte-stream requesters. Each requester presents framed messages (valid/ready/data plus `last`). The arbiter locks the transmitter to one requester for a whole message, so bytes from different sources never interleave on the serial line. An idle-timeout watchdog releases a requester that stalls mid-message. It sits between the firmware/logging sources and the `quick_uart_tx` `valid_i`/`ready_o`/`data_i` port.

---
 rtl/quick_uart_tx_arb.sv | 155 +++++++++++++++
 tb/tb_quick_uart_tx_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_uart_tx_arb.sv
// quick_uart_tx_arb: round-robin, message-locked arbiter that shares one
// quick_uart_tx among N_REQ framed byte streams. A requester keeps the
// transmitter from its first accepted request until its last byte is taken,
// or until it stalls for TIMEOUT cycles mid-message.
module quick_uart_tx_arb #(
   parameter int N_REQ     = 4,
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [N_REQ-1:0]             req_valid_i,
   input  logic [N_REQ*DATA_BITS-1:0]   req_data_i,
   input  logic [N_REQ-1:0]             req_last_i,
   output logic [N_REQ-1:0]             req_ready_o,
   output logic                         tx_valid_o,
   output logic [DATA_BITS-1:0]         tx_data_o,
   input  logic                         tx_ready_i,
   output logic [N_REQ-1:0]             grant_o,
   output logic                         busy_o,
   output logic                         timeout_o
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             timeout_q, timeout_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_valid;
   logic             owner_last;
   logic [DATA_BITS-1:0] owner_data;
   logic             expire;

   // Successor of a requester index with modulo-N_REQ wrap.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_REQ - 1)) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

   assign owner_valid = req_valid_i[gnt_idx_q];
   assign owner_last  = req_last_i[gnt_idx_q];
   assign owner_data  = req_data_i[gnt_idx_q*DATA_BITS +: DATA_BITS];

   // The stall that brings the counter up to TIMEOUT is the one that releases the grant.
   assign expire = (TIMEOUT > 0) && (state_q == ST_LOCKED) && !owner_valid &&
                   (stall_q == CNT_MAX - CNT_W'(1));

   // First valid requester at or after rr_ptr, searching upward with wrap.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!pick_found && req_valid_i[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Next-state logic plus the combinational owner mux onto the transmitter port.
   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      rr_ptr_d    = rr_ptr_q;
      stall_d     = stall_q;
      timeout_d   = 1'b0;
      req_ready_o = '0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      case (state_q)
         ST_IDLE: begin
            stall_d = '0;
            if (pick_found) begin
               state_d   = ST_LOCKED;
               gnt_idx_d = pick_idx;
            end
         end
         ST_LOCKED: begin
            tx_valid_o             = owner_valid;
            tx_data_o              = owner_data;
            req_ready_o[gnt_idx_q] = tx_ready_i;
            if (owner_valid) begin
               stall_d = '0;
               if (tx_ready_i && owner_last) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = next_idx(gnt_idx_q);
               end
            end else if (expire) begin
               state_d   = ST_IDLE;
               rr_ptr_d  = next_idx(gnt_idx_q);
               timeout_d = 1'b1;
               stall_d   = '0;
            end else if (stall_q != CNT_MAX) begin
               stall_d = stall_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, owner, pointer, watchdog and pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   // Status outputs are decoded purely from registers.
   always_comb begin
      grant_o = '0;
      if (state_q == ST_LOCKED) begin
         grant_o[gnt_idx_q] = 1'b1;
      end
   end

   assign busy_o    = (state_q == ST_LOCKED);
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_quick_uart_tx_arb.sv
// Bench for quick_uart_tx_arb (N_REQ=4, DATA_BITS=8, TIMEOUT=8): a directed
// vector table, hand-written multi-cycle sequences and a randomized run
// compared cycle by cycle against an owner/pointer reference model.
module tb_quick_uart_tx_arb;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [N-1:0]  req_valid;
   logic [N*DB-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic          tx_valid;
   logic [DB-1:0] tx_data;
   logic          tx_ready;
   logic [N-1:0]  grant;
   logic          busy;
   logic          tout;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner index (-1 when idle), pointer, stall count, pulse.
   int m_owner;
   int m_ptr;
   int m_stall;
   logic m_to;

   // Outputs observed at the last sampling point.
   logic [N-1:0]  obs_grant;
   logic [N-1:0]  obs_ready;
   logic          obs_busy, obs_to, obs_txv, obs_hs;
   logic [DB-1:0] obs_txd;

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic       r;
      logic [3:0] g;
      logic       b;
      logic [3:0] rdy;
      logic       tv;
      logic [7:0] td;
   } vec_t;

   vec_t tbl[16];

   logic [7:0] hsq[$];
   logic [3:0] gq[$];
   int   exp_k[5] = '{0, 1, 2, 3, 0};
   logic [7:0] ni_exp[4] = '{8'hA5, 8'h5A, 8'hFF, 8'h3C};
   logic [7:0] ni_b[3]   = '{8'hA5, 8'h5A, 8'hFF};
   logic [7:0] bp_b[3]   = '{8'h11, 8'h22, 8'h33};

   int   i1, gap, cyc, idx, bp, stall_cnt, idle_cnt;
   bit   done2, seen_to, prev_busy;
   logic [3:0]  bn, v, l;
   logic [31:0] d;
   logic        r;
   logic        v1, v2;

   quick_uart_tx_arb #(
      .N_REQ    (N),
      .DATA_BITS(DB),
      .TIMEOUT  (TO)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .req_valid_i(req_valid),
      .req_data_i (req_data),
      .req_last_i (req_last),
      .req_ready_o(req_ready),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .tx_ready_i (tx_ready),
      .grant_o    (grant),
      .busy_o     (busy),
      .timeout_o  (tout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_stall = 0;
      m_to    = 1'b0;
   endtask

   // One clock of the message-level rules, evaluated on the inputs present at the edge.
   task automatic model_step();
      bit found;
      int k;
      m_to  = 1'b0;
      found = 1'b0;
      if (m_owner < 0) begin
         for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (!found && req_valid[k]) begin
               found   = 1'b1;
               m_owner = k;
               m_stall = 0;
            end
         end
      end else if (req_valid[m_owner]) begin
         m_stall = 0;
         if (tx_ready && req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else begin
         m_stall = m_stall + 1;
         if (m_stall == TO) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_stall = 0;
         end
      end
   endtask

   task automatic check_model(input string name);
      logic [3:0] eg, er;
      logic       eb, etv;
      logic [7:0] etd;
      eg = '0; er = '0; eb = 1'b0; etv = 1'b0; etd = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         eb          = 1'b1;
         er[m_owner] = tx_ready;
         etv         = req_valid[m_owner];
         etd         = req_data[m_owner*DB +: DB];
      end
      chk(name, 32'({grant, busy, tout, req_ready, tx_valid, tx_data}),
                32'({eg, eb, m_to, er, etv, etd}));
   endtask

   // Called just after a rising edge: drive, sample at the falling edge, step the model.
   task automatic do_cycle(input logic [3:0] av, input logic [3:0] al,
                           input logic [31:0] ad, input logic ar);
      req_valid = av;
      req_last  = al;
      req_data  = ad;
      tx_ready  = ar;
      @(negedge clk);
      check_model("model_cmp");
      obs_grant = grant;
      obs_ready = req_ready;
      obs_busy  = busy;
      obs_to    = tout;
      obs_txv   = tx_valid;
      obs_txd   = tx_data;
      obs_hs    = tx_valid && tx_ready;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      model_reset();
      @(negedge clk);
      check_model("reset_cmp");
      rst_ni = 1'b1;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      tbl[0]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[1]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA1};
      tbl[2]  = '{4'b0110, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1, 8'hA1};
      tbl[3]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA1};
      tbl[4]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[5]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2};
      tbl[6]  = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[7]  = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hA3};
      tbl[8]  = '{4'b1001, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[9]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
      tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[12] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
      tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'hA0};
      tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0};
      tbl[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

      // Reset with every requester asking: everything stays low.
      rst_ni    = 1'b0;
      req_valid = 4'hF;
      req_last  = 4'h0;
      req_data  = 32'h44332211;
      tx_ready  = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_outputs_a", 32'({grant, busy, tout, req_ready, tx_valid, tx_data}), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_outputs_b", 32'({grant, busy, tout, req_ready, tx_valid, tx_data}), 32'h0);
      rst_ni = 1'b1;
      @(posedge clk);
      model_step();
      #1;
      do_cycle(4'hF, 4'h0, 32'h44332211, 1'b1);
      chk("rst_release_grant", 32'(obs_grant), 32'h1);
      chk("rst_release_busy", 32'(obs_busy), 32'h1);

      // Directed vector table from a fresh reset.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req_valid = tbl[i].v;
         req_last  = tbl[i].l;
         req_data  = 32'hA3A2A1A0;
         tx_ready  = tbl[i].r;
         @(negedge clk);
         chk($sformatf("tbl_row%0d", i),
             32'({grant, busy, tout, req_ready, tx_valid, tx_data}),
             32'({tbl[i].g, tbl[i].b, 1'b0, tbl[i].rdy, tbl[i].tv, tbl[i].td}));
         @(posedge clk);
         model_step();
         #1;
      end

      // Fairness: all four stream 2-byte messages back to back.
      do_reset();
      bn = '0; idle_cnt = 0; prev_busy = 1'b0;
      hsq.delete(); gq.delete();
      for (int c = 0; c < 15; c++) begin
         for (int k = 0; k < N; k++) d[k*8 +: 8] = {4'(k), 3'b000, bn[k]};
         do_cycle(4'hF, bn, d, 1'b1);
         if (obs_busy && !prev_busy) gq.push_back(obs_grant);
         if (!obs_busy && c > 0) idle_cnt++;
         if (obs_hs) begin
            hsq.push_back(obs_txd);
            for (int k = 0; k < N; k++) if (obs_grant[k]) bn[k] = ~bn[k];
         end
         prev_busy = obs_busy;
      end
      chk("rr_grants", 32'(gq.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < gq.size()) chk($sformatf("rr_order%0d", i), 32'(gq[i]), 32'(1 << exp_k[i]));
      chk("rr_idle_gaps", 32'(idle_cnt), 32'd4);
      chk("rr_bytes", 32'(hsq.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < hsq.size())
            chk($sformatf("rr_byte%0d", i), 32'(hsq[i]), 32'((exp_k[i/2] << 4) | (i % 2)));

      // No interleave: requester 1 pauses mid-message while requester 2 waits.
      do_reset();
      i1 = 0; gap = 0; done2 = 1'b0; cyc = 0;
      hsq.delete();
      while (hsq.size() < 4 && cyc < 40) begin
         v1 = (i1 < 3) && !(i1 == 1 && gap < 5);
         v2 = !done2;
         d  = {8'h00, 8'h3C, (i1 < 3) ? ni_b[i1] : 8'h00, 8'h00};
         l  = {1'b0, 1'b1, (i1 == 2), 1'b0};
         do_cycle({1'b0, v2, v1, 1'b0}, l, d, 1'b1);
         if (obs_hs) begin
            hsq.push_back(obs_txd);
            if (obs_grant[1]) i1++;
            if (obs_grant[2]) done2 = 1'b1;
         end
         if (i1 == 1 && !v1) gap++;
         cyc++;
      end
      chk("ni_count", 32'(hsq.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < hsq.size()) chk($sformatf("ni_byte%0d", i), 32'(hsq[i]), 32'(ni_exp[i]));

      // Backpressure: tx_ready low for 40 cycles after the first byte.
      do_reset();
      idx = 0; bp = 0; cyc = 0;
      while (idx < 3 && cyc < 80) begin
         r = !(idx == 1 && bp < 40);
         d = {24'h0, bp_b[idx]};
         l = {3'b000, (idx == 2)};
         do_cycle(4'b0001, l, d, r);
         if (idx == 1 && bp < 40) begin
            chk("bp_data", 32'(obs_txd), 32'h22);
            chk("bp_ready", 32'(obs_ready), 32'h0);
            chk("bp_tout", 32'(obs_to), 32'h0);
            bp++;
         end
         if (obs_hs) idx++;
         cyc++;
      end
      chk("bp_done", 32'(idx), 32'd3);

      // Watchdog: requester 0 goes silent after one byte, requester 1 waits.
      do_reset();
      seen_to = 1'b0; stall_cnt = 0; cyc = 0; idx = 0;
      while (!seen_to && cyc < 30) begin
         do_cycle({2'b00, 1'b1, (idx == 0)}, 4'b0010, 32'h0000B1B0, 1'b1);
         if (obs_to) begin
            seen_to = 1'b1;
            chk("wd_stall_cycles", 32'(stall_cnt), 32'd8);
            chk("wd_busy_on_pulse", 32'(obs_busy), 32'h0);
         end else begin
            if (obs_busy && obs_grant == 4'b0001 && !obs_txv) stall_cnt++;
            if (obs_hs && obs_grant == 4'b0001) idx = 1;
         end
         cyc++;
      end
      chk("wd_seen", 32'(seen_to), 32'h1);
      do_cycle(4'b0010, 4'b0010, 32'h0000B1B0, 1'b0);
      chk("wd_pulse_width", 32'(obs_to), 32'h0);
      chk("wd_next_grant", 32'(obs_grant), 32'h2);

      // Randomized traffic against the model, alternating busy and sparse phases.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int pv;
         pv = (((i / 150) % 2) == 1) ? 15 : 75;
         for (int k = 0; k < N; k++) begin
            v[k] = ($urandom_range(99) < pv);
            l[k] = ($urandom_range(99) < 30);
         end
         d = $urandom;
         r = ($urandom_range(99) < 60);
         do_cycle(v, l, d, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
